// File: rtl/fp16_cvt_scheduler.sv
// fp16_cvt_scheduler
// Shares one combinational INT32->FP16 converter between N_REQ Sobol
// dimension generators. A round-robin arbiter grants one requester at a
// time into stage S1 (which drives the converter input from a register).
// Stage S2 captures the converter result together with the requester ID
// and presents it on a single backpressured output stream.
//
// Handshake semantics (both the request side and the output side):
//   A transfer happens on a rising clock edge where valid and ready are
//   both high. The producer may raise or drop valid at any cycle; a word
//   whose valid drops before it is granted is skipped. Ready is never
//   derived from the same port's valid except through arbitration, and
//   output data is held stable while out_valid is high and out_ready is low.

module fp16_cvt_scheduler #(
   parameter int N_REQ = 4,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [32*N_REQ-1:0]  req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic [31:0]          cvt_int32,
   input  logic [15:0]          cvt_fp16,
   output logic                 out_valid,
   output logic [15:0]          out_fp16,
   output logic [IDW-1:0]       out_id,
   input  logic                 out_ready,
   output logic [15:0]          conv_cnt,
   output logic                 idle
);

   // Round-robin pointer: index searched first for the next grant.
   logic [IDW-1:0] ptr;

   // Stage S1 bookkeeping (cvt_int32 is the S1 data register).
   logic           s1_valid;
   logic [IDW-1:0] s1_id;

   // Pipeline flow control.
   logic s2_take;
   logic s1_adv;
   logic s1_take;
   logic grant_ok;

   // Arbiter results.
   logic           gnt_found;
   logic [IDW-1:0] gnt_idx;
   logic [IDW:0]   sum_c;
   logic           req_hs;

   // S2 can load whenever it is empty or its word leaves this cycle.
   always_comb begin
      s2_take  = !out_valid || out_ready;
      s1_adv   = s1_valid && s2_take;
      s1_take  = !s1_valid || s1_adv;
      grant_ok = en && s1_take && !rst;
   end

   // Round-robin search over req_valid starting at ptr, wrapping to 0.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      sum_c     = '0;
      for (int off = 0; off < N_REQ; off++) begin
         sum_c = {1'b0, ptr} + (IDW+1)'(off);
         if (sum_c >= (IDW+1)'(N_REQ)) begin
            sum_c = sum_c - (IDW+1)'(N_REQ);
         end
         if (!gnt_found && req_valid[sum_c[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = sum_c[IDW-1:0];
         end
      end
   end

   // One-hot grant, only when S1 can take a word and granting is enabled.
   always_comb begin
      req_ready = '0;
      req_hs    = 1'b0;
      if (grant_ok && gnt_found) begin
         req_ready[gnt_idx] = 1'b1;
         req_hs             = 1'b1;
      end
   end

   // Pointer moves past the granted requester, only on a request handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (req_hs) begin
         if (gnt_idx == IDW'(N_REQ-1)) begin
            ptr <= '0;
         end else begin
            ptr <= gnt_idx + 1'b1;
         end
      end
   end

   // Stage S1: load the granted word; cvt_int32 holds when S1 empties so
   // the converter input does not toggle needlessly.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_id     <= '0;
         cvt_int32 <= '0;
      end else if (req_hs) begin
         s1_valid  <= 1'b1;
         s1_id     <= gnt_idx;
         cvt_int32 <= req_data[int'(gnt_idx)*32 +: 32];
      end else if (s1_adv) begin
         s1_valid  <= 1'b0;
      end
   end

   // Stage S2: capture converter result and ID; hold under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_fp16  <= '0;
         out_id    <= '0;
      end else if (s1_adv) begin
         out_valid <= 1'b1;
         out_fp16  <= cvt_fp16;
         out_id    <= s1_id;
      end else if (s2_take) begin
         out_valid <= 1'b0;
      end
   end

   // Count completed output handshakes, wrapping at 16 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         conv_cnt <= '0;
      end else if (out_valid && out_ready) begin
         conv_cnt <= conv_cnt + 16'd1;
      end
   end

   // Idle is a pure function of the stage valid registers.
   always_comb begin
      idle = !s1_valid && !out_valid;
   end

endmodule

// File: tb/tb_fp16_cvt_scheduler.sv
// Testbench for fp16_cvt_scheduler: directed scenarios followed by random
// traffic, checked against a word-level model of a two-deep pipeline with a
// round-robin arbiter. Expected outputs go into exp_q at grant time; a
// separate monitor pops and compares on every output handshake.

module tb_fp16_cvt_scheduler;

   localparam int N_REQ = 4;
   localparam int IDW   = 2;
   localparam int EW    = IDW + 16;

   // ---------------- clock / reset / DUT ----------------
   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic [N_REQ-1:0]    req_valid;
   logic [32*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]    req_ready;
   logic [31:0]         cvt_int32;
   logic [15:0]         cvt_fp16;
   logic                out_valid;
   logic [15:0]         out_fp16;
   logic [IDW-1:0]      out_id;
   logic                out_ready;
   logic [15:0]         conv_cnt;
   logic                idle;

   always #5 clk = ~clk;

   // Stub converter: upper half of the integer word.
   assign cvt_fp16 = cvt_int32[31:16];

   fp16_cvt_scheduler #(.N_REQ(N_REQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .cvt_int32 (cvt_int32),
      .cvt_fp16  (cvt_fp16),
      .out_valid (out_valid),
      .out_fp16  (out_fp16),
      .out_id    (out_id),
      .out_ready (out_ready),
      .conv_cnt  (conv_cnt),
      .idle      (idle)
   );

   // ---------------- scoreboard state ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [EW-1:0] exp_q[$];

   // Reference model: words in flight (oldest first), whether the newest
   // was granted at the last edge, arbiter pointer, count, last S1 word.
   logic [EW-1:0] mdl_q[$];
   bit            tail_fresh;
   int            m_ptr;
   logic [15:0]   m_cnt;
   logic [31:0]   m_last;
   logic [EW-1:0] mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N_REQ-1:0] v, input int p);
      for (int off = 0; off < N_REQ; off++) begin
         if (v[(p + off) % N_REQ]) return (p + off) % N_REQ;
      end
      return -1;
   endfunction

   // ---------------- one clock of checking + model update ----------------
   task automatic cycle();
      int               g;
      bit               can;
      bit               exp_ov;
      bit               out_hs;
      logic [N_REQ-1:0] exp_rdy;
      logic [EW-1:0]    head;
      logic [EW-1:0]    ent;
      @(negedge clk);
      exp_ov  = (mdl_q.size() > 1) || (mdl_q.size() == 1 && !tail_fresh);
      can     = en && !rst && (mdl_q.size() < 2 || out_ready);
      g       = can ? pick(req_valid, m_ptr) : -1;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("idle", 32'(idle), 32'(mdl_q.size() == 0));
      chk("conv_cnt", 32'(conv_cnt), 32'(m_cnt));
      chk("cvt_int32", cvt_int32, m_last);
      if (exp_ov) begin
         head = mdl_q[0];
         chk("out_fp16", 32'(out_fp16), 32'(head[15:0]));
         chk("out_id", 32'(out_id), 32'(head[EW-1:16]));
      end
      out_hs = exp_ov && out_ready && !rst;
      @(posedge clk);
      #1;
      if (rst) begin
         mdl_q.delete();
         exp_q.delete();
         tail_fresh = 1'b0;
         m_ptr      = 0;
         m_cnt      = '0;
         m_last     = '0;
      end else begin
         tail_fresh = 1'b0;
         if (out_hs) begin
            void'(mdl_q.pop_front());
            m_cnt = m_cnt + 16'd1;
         end
         if (g >= 0) begin
            m_last = req_data[32*g +: 32];
            ent    = {IDW'(g), m_last[31:16]};
            mdl_q.push_back(ent);
            exp_q.push_back(ent);
            tail_fresh = 1'b1;
            m_ptr      = (g + 1) % N_REQ;
         end
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic set_data(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
      req_data = {d3, d2, d1, d0};
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL mon_unexpected: got id %0d fp16 0x%h, expected no output", out_id, out_fp16);
         end else begin
            mon_e = exp_q.pop_front();
            chk("mon_fp16", 32'(out_fp16), 32'(mon_e[15:0]));
            chk("mon_id", 32'(out_id), 32'(mon_e[EW-1:16]));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst       = 1'b1;
      en        = 1'b1;
      out_ready = 1'b1;
      req_valid = '1;
      set_data(32'h0, 32'h0, 32'h0, 32'h0);
      tail_fresh = 1'b0;
      m_ptr      = 0;
      m_cnt      = '0;
      m_last     = '0;
      @(posedge clk);
      #1;

      // Reset held for two cycles with every requester asking.
      cycles(2);

      // Single request from requester 0.
      rst       = 1'b0;
      req_valid = 4'b0001;
      set_data(32'h03320000, 32'h0, 32'h0, 32'h0);
      cycle();
      req_valid = '0;
      cycles(3);

      // Round-robin with all requesters valid.
      set_data(32'h06C40000, 32'h0D880000, 32'h1BD00000, 32'h37600000);
      req_valid = '1;
      cycles(9);
      req_valid = '0;
      cycles(3);

      // Backpressure for five cycles, then release.
      req_valid = '1;
      out_ready = 1'b0;
      cycles(5);
      out_ready = 1'b1;
      cycles(3);
      req_valid = '0;
      cycles(3);

      // Fill both stages, then drop en and drain.
      req_valid = '1;
      out_ready = 1'b0;
      cycles(2);
      en = 1'b0;
      cycles(2);
      out_ready = 1'b1;
      cycles(4);
      en        = 1'b1;
      req_valid = '0;
      cycles(1);

      // Reset in the middle of traffic.
      req_valid = '1;
      cycles(4);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycles(4);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         req_valid = N_REQ'($urandom);
         set_data($urandom, $urandom, $urandom, $urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         en        = ($urandom_range(0, 9) < 9);
         rst       = ($urandom_range(0, 199) == 0);
         cycle();
      end

      // Drain everything still in flight.
      rst       = 1'b0;
      en        = 1'b1;
      req_valid = '0;
      out_ready = 1'b1;
      cycles(4);
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
